// File: rtl/lu_pkg.sv
// Shared definitions for the multicycle logic unit: op codes,
// shift modes, FSM state encoding and op classification helpers.
package lu_pkg;

    localparam logic [3:0] LU_OP_PASS_A = 4'd0;
    localparam logic [3:0] LU_OP_ADD    = 4'd1;
    localparam logic [3:0] LU_OP_SUB    = 4'd2;
    localparam logic [3:0] LU_OP_AND    = 4'd3;
    localparam logic [3:0] LU_OP_OR     = 4'd4;
    localparam logic [3:0] LU_OP_XOR    = 4'd5;
    localparam logic [3:0] LU_OP_NOT_A  = 4'd6;
    localparam logic [3:0] LU_OP_INC_A  = 4'd7;
    localparam logic [3:0] LU_OP_SLT    = 4'd8;
    localparam logic [3:0] LU_OP_SLL    = 4'd9;
    localparam logic [3:0] LU_OP_SRL    = 4'd10;
    localparam logic [3:0] LU_OP_SRA    = 4'd11;
    localparam logic [3:0] LU_OP_ROR    = 4'd12;
    localparam logic [3:0] LU_OP_BEQ    = 4'd13;
    localparam logic [3:0] LU_OP_BNE    = 4'd14;
    localparam logic [3:0] LU_OP_BGT    = 4'd15;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= LU_OP_SLL) && (op <= LU_OP_ROR);
    endfunction

    // Shift ops are contiguous, so the mode is the offset from SLL.
    function automatic logic [1:0] shift_mode(input logic [3:0] op);
        logic [3:0] d;
        d = op - LU_OP_SLL;
        return d[1:0];
    endfunction

endpackage

// File: rtl/logic_unit_mc_if.sv
// Request/response bundle between the control unit and logic_unit_mc.
// master: control side (drives op/operands); slave: execution unit.
interface logic_unit_mc_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();

    logic               start;
    logic [3:0]         alu_op;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [SHAMT_W-1:0] shamt;
    logic               shamt_sel;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   alu_out;
    logic               zero;
    logic               overflow;
    logic               special;
    logic               br_taken;

    modport master (
        output start, alu_op, src_a, src_b, shamt, shamt_sel,
        input  busy, done, alu_out, zero, overflow, special, br_taken
    );

    modport slave (
        input  start, alu_op, src_a, src_b, shamt, shamt_sel,
        output busy, done, alu_out, zero, overflow, special, br_taken
    );

endinterface

// File: rtl/lu_shift_iter.sv
// Shifter for logic_unit_mc: one bit per cycle after load, or a
// combinational barrel shifter when LU_SHIFT_FAST_EN is defined.
// Ports: clk, reset, load, mode (SLL/SRL/SRA/ROR), amount, operand,
// result, finished (high when no shift steps remain).
module lu_shift_iter
    import lu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [WIDTH-1:0]   operand,
    output logic [WIDTH-1:0]   result,
    output logic               finished
);

`ifdef LU_SHIFT_FAST_EN

    logic unused_ok;
    logic [2*WIDTH-1:0] rot;

    assign unused_ok = ^{clk, reset, load};

    always_comb begin
        rot    = {operand, operand} >> amount;
        result = '0;
        unique case (mode)
            SH_SLL: result = operand << amount;
            SH_SRL: result = operand >> amount;
            SH_SRA: result = $signed(operand) >>> amount;
            SH_ROR: result = rot[WIDTH-1:0];
            default: result = '0;
        endcase
    end

    assign finished = 1'b1;

`else

    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   step;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         mode_q;

    always_comb begin
        step = shreg;
        unique case (mode_q)
            SH_SLL: step = {shreg[WIDTH-2:0], 1'b0};
            SH_SRL: step = {1'b0, shreg[WIDTH-1:1]};
            SH_SRA: step = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            SH_ROR: step = {shreg[0], shreg[WIDTH-1:1]};
            default: step = shreg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
            cnt    <= '0;
            mode_q <= SH_SLL;
        end else if (load) begin
            shreg  <= operand;
            cnt    <= amount;
            mode_q <= mode;
        end else if (cnt != '0) begin
            shreg <= step;
            cnt   <= cnt - 1'b1;
        end
    end

    assign result   = shreg;
    assign finished = (cnt == '0);

`endif

endmodule

// File: rtl/logic_unit_mc.sv
// Multicycle execution unit: ALU, shifter and branch compare behind a
// start/done handshake. Ports: clk, reset (sync, active high), bus
// (logic_unit_mc_if.slave). LU_SHIFT_FAST_EN selects 1-cycle shifts.
module logic_unit_mc
    import lu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    logic_unit_mc_if.slave bus
);

    localparam int MSB = WIDTH - 1;

    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
        $error("SHAMT_W must equal clog2(WIDTH)");
    end
    if (WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be at least 8");
    end

    state_t             state;
    state_t             state_nxt;
    logic               shift_op;
    logic [1:0]         sh_mode;
    logic [SHAMT_W-1:0] sh_amt;
    logic               sh_load;
    logic [WIDTH-1:0]   sh_res;
    logic               sh_fin;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res;
    logic               ovf;
    logic               spc;
    logic               br;

    assign shift_op = is_shift_op(bus.alu_op);
    assign sh_mode  = shift_mode(bus.alu_op);
    assign sh_amt   = bus.shamt_sel ? bus.src_a[SHAMT_W-1:0]
                                    : bus.shamt;

    lu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .mode     (sh_mode),
        .amount   (sh_amt),
        .operand  (bus.src_b),
        .result   (sh_res),
        .finished (sh_fin)
    );

    always_comb begin
        sum  = bus.src_a + bus.src_b;
        diff = bus.src_a - bus.src_b;
        spc  = $signed(bus.src_a) < $signed(bus.src_b);
        res  = '0;
        ovf  = 1'b0;
        br   = 1'b0;
        unique case (bus.alu_op)
            LU_OP_PASS_A: res = bus.src_a;
            LU_OP_ADD: begin
                res = sum;
                ovf = (bus.src_a[MSB] == bus.src_b[MSB]) &&
                      (sum[MSB] != bus.src_a[MSB]);
            end
            LU_OP_SUB: begin
                res = diff;
                ovf = (bus.src_a[MSB] != bus.src_b[MSB]) &&
                      (diff[MSB] != bus.src_a[MSB]);
            end
            LU_OP_AND:   res = bus.src_a & bus.src_b;
            LU_OP_OR:    res = bus.src_a | bus.src_b;
            LU_OP_XOR:   res = bus.src_a ^ bus.src_b;
            LU_OP_NOT_A: res = ~bus.src_a;
            LU_OP_INC_A: begin
                res = bus.src_a + WIDTH'(1);
                // A+1 can only overflow going from max positive.
                ovf = !bus.src_a[MSB] && res[MSB];
            end
            LU_OP_SLT: res = WIDTH'(spc);
            LU_OP_SLL, LU_OP_SRL,
            LU_OP_SRA, LU_OP_ROR: res = sh_res;
            LU_OP_BEQ: begin
                res = diff;
                br  = (diff == '0);
            end
            LU_OP_BNE: begin
                res = diff;
                br  = (diff != '0);
            end
            LU_OP_BGT: begin
                res = diff;
                br  = $signed(bus.src_a) > $signed(bus.src_b);
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef LU_SHIFT_FAST_EN
                    state_nxt = ST_DONE;
`else
                    state_nxt = shift_op ? ST_SHIFT : ST_DONE;
`endif
                end
            end
`ifndef LU_SHIFT_FAST_EN
            ST_SHIFT: state_nxt = sh_fin ? ST_DONE : ST_SHIFT;
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == ST_SHIFT);
        bus.done = (state == ST_DONE);
        sh_load  = (state == ST_IDLE) && bus.start && shift_op;
    end

`ifdef LU_SHIFT_FAST_EN
    logic unused_fin;
    assign unused_fin = sh_fin;
`else
    // special is taken from the operands seen at start, not the
    // live inputs present when the shift finishes.
    logic spec_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_out  <= '0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.special  <= 1'b0;
            bus.br_taken <= 1'b0;
`ifndef LU_SHIFT_FAST_EN
            spec_q       <= 1'b0;
`endif
        end else if (state == ST_IDLE && bus.start) begin
`ifndef LU_SHIFT_FAST_EN
            if (shift_op) begin
                spec_q <= spc;
            end else
`endif
            begin
                bus.alu_out  <= res;
                bus.zero     <= (res == '0);
                bus.overflow <= ovf;
                bus.special  <= spc;
                bus.br_taken <= br;
            end
        end
`ifndef LU_SHIFT_FAST_EN
        else if (state == ST_SHIFT && sh_fin) begin
            bus.alu_out  <= sh_res;
            bus.zero     <= (sh_res == '0);
            bus.overflow <= 1'b0;
            bus.special  <= spec_q;
            bus.br_taken <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_logic_unit_mc.sv
// Self-checking bench for logic_unit_mc: 32- and 16-bit instances,
// vector table with a scoreboard queue plus handshake corner cases.
module tb_logic_unit_mc;
    import lu_pkg::*;

    typedef struct {
        logic        w16;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic        sel;
        logic [31:0] out;
        logic        z;
        logic        ov;
        logic        sp;
        logic        br;
        int          amt;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        z;
        logic        ov;
        logic        sp;
        logic        br;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    exp_t sbq[$];
    vec_t tbl[19];

    always #5 clk = ~clk;

    logic_unit_mc_if #(.WIDTH(32), .SHAMT_W(5)) i32 ();
    logic_unit_mc_if #(.WIDTH(16), .SHAMT_W(4)) i16 ();

    logic_unit_mc #(.WIDTH(32), .SHAMT_W(5)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (i32.slave)
    );

    logic_unit_mc #(.WIDTH(16), .SHAMT_W(4)) u16 (
        .clk   (clk),
        .reset (reset),
        .bus   (i16.slave)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op, input int amt);
`ifdef LU_SHIFT_FAST_EN
        return 1;
`else
        return is_shift_op(op) ? amt + 2 : 1;
`endif
    endfunction

    function automatic int exp_busy(input logic [3:0] op, input int amt);
`ifdef LU_SHIFT_FAST_EN
        return 0;
`else
        return is_shift_op(op) ? amt + 1 : 0;
`endif
    endfunction

    function automatic logic dn(input logic w);
        return w ? i16.done : i32.done;
    endfunction

    function automatic logic bz(input logic w);
        return w ? i16.busy : i32.busy;
    endfunction

    task automatic get_out(input logic w, output exp_t o);
        if (w) begin
            o.out = {16'h0, i16.alu_out};
            o.z = i16.zero; o.ov = i16.overflow;
            o.sp = i16.special; o.br = i16.br_taken;
        end else begin
            o.out = i32.alu_out;
            o.z = i32.zero; o.ov = i32.overflow;
            o.sp = i32.special; o.br = i32.br_taken;
        end
    endtask

    task automatic cmp_pop(input string tag, input logic w);
        exp_t e;
        exp_t o;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: done with empty scoreboard", tag);
            return;
        end
        e = sbq.pop_front();
        get_out(w, o);
        check({tag, ".out"}, o.out, e.out);
        check({tag, ".zero"}, 32'(o.z), 32'(e.z));
        check({tag, ".ovf"}, 32'(o.ov), 32'(e.ov));
        check({tag, ".special"}, 32'(o.sp), 32'(e.sp));
        check({tag, ".br"}, 32'(o.br), 32'(e.br));
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        if (v.w16) begin
            i16.start = 1'b1; i16.alu_op = v.op;
            i16.src_a = v.a[15:0]; i16.src_b = v.b[15:0];
            i16.shamt = v.shamt[3:0]; i16.shamt_sel = v.sel;
        end else begin
            i32.start = 1'b1; i32.alu_op = v.op;
            i32.src_a = v.a; i32.src_b = v.b;
            i32.shamt = v.shamt; i32.shamt_sel = v.sel;
        end
        sbq.push_back('{v.out, v.z, v.ov, v.sp, v.br});
    endtask

    // Deassert start and scramble operands to prove they were captured.
    task automatic release_inputs(input logic w);
        if (w) begin
            i16.start = 1'b0;
            i16.src_a = 16'($urandom); i16.src_b = 16'($urandom);
            i16.shamt = 4'($urandom);
        end else begin
            i32.start = 1'b0;
            i32.src_a = $urandom; i32.src_b = $urandom;
            i32.shamt = 5'($urandom);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int busy_n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(v);
        @(posedge clk); #1;
        release_inputs(v.w16);
        n = 1;
        busy_n = 0;
        while (!dn(v.w16) && n < 100) begin
            if (bz(v.w16)) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        if (!dn(v.w16)) begin
            checks++; errors++;
            $display("FAIL %s: no done within %0d cycles", tag, n);
            void'(sbq.pop_front());
            return;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat(v.op, v.amt)));
        check({tag, ".busy"}, 32'(busy_n), 32'(exp_busy(v.op, v.amt)));
        cmp_pop(tag, v.w16);
        @(posedge clk); #1;
        check({tag, ".pulse"}, 32'(dn(v.w16)), 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".busy"}, 32'(i32.busy), 32'd0);
        check({tag, ".done"}, 32'(i32.done), 32'd0);
        check({tag, ".out"}, i32.alu_out, 32'd0);
        check({tag, ".zero"}, 32'(i32.zero), 32'd0);
        check({tag, ".ovf"}, 32'(i32.overflow), 32'd0);
        check({tag, ".special"}, 32'(i32.special), 32'd0);
        check({tag, ".br"}, 32'(i32.br_taken), 32'd0);
    endtask

    initial begin
        int dones;
        int start_k;
        vec_t v;

        //        w16 op            a             b             sh  sel out           z  ov sp br amt
        tbl[0]  = '{0, LU_OP_ADD,    32'h7FFFFFFF, 32'h00000001, 0,  0, 32'h80000000, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, LU_OP_SUB,    32'h00001234, 32'h00001234, 0,  0, 32'h00000000, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, LU_OP_BEQ,    32'h00001234, 32'h00001234, 0,  0, 32'h00000000, 1, 0, 0, 1, 0};
        tbl[3]  = '{0, LU_OP_BNE,    32'h00001234, 32'h00001234, 0,  0, 32'h00000000, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, LU_OP_SLT,    32'hFFFFFFFF, 32'h00000001, 0,  0, 32'h00000001, 0, 0, 1, 0, 0};
        tbl[5]  = '{0, LU_OP_SRA,    32'h00000000, 32'hF0000000, 4,  0, 32'hFF000000, 0, 0, 0, 0, 4};
        tbl[6]  = '{0, LU_OP_ROR,    32'h00000021, 32'h00000001, 0,  1, 32'h80000000, 0, 0, 0, 0, 1};
        tbl[7]  = '{0, LU_OP_SLL,    32'h00000000, 32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, LU_OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 0,  0, 32'hF000F000, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, LU_OP_OR,     32'h00000000, 32'h00000000, 0,  0, 32'h00000000, 1, 0, 0, 0, 0};
        tbl[10] = '{0, LU_OP_XOR,    32'hAAAAAAAA, 32'hFFFFFFFF, 0,  0, 32'h55555555, 0, 0, 1, 0, 0};
        tbl[11] = '{0, LU_OP_NOT_A,  32'h00000000, 32'h00000000, 0,  0, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
        tbl[12] = '{0, LU_OP_INC_A,  32'h7FFFFFFF, 32'h00000000, 0,  0, 32'h80000000, 0, 1, 0, 0, 0};
        tbl[13] = '{0, LU_OP_PASS_A, 32'h12345678, 32'h12345679, 0,  0, 32'h12345678, 0, 0, 1, 0, 0};
        tbl[14] = '{0, LU_OP_BGT,    32'h00000005, 32'hFFFFFFFF, 0,  0, 32'h00000006, 0, 0, 0, 1, 0};
        tbl[15] = '{0, LU_OP_SUB,    32'h80000000, 32'h00000001, 0,  0, 32'h7FFFFFFF, 0, 1, 1, 0, 0};
        tbl[16] = '{0, LU_OP_SRL,    32'h0000003F, 32'h80000000, 0,  1, 32'h00000001, 0, 0, 0, 0, 31};
        tbl[17] = '{1, LU_OP_ADD,    32'h0000FFFF, 32'h00000001, 0,  0, 32'h00000000, 1, 0, 1, 0, 0};
        tbl[18] = '{1, LU_OP_SRL,    32'h00000000, 32'h00008000, 15, 0, 32'h00000001, 0, 0, 0, 0, 15};

        i32.start = 0; i32.alu_op = 0; i32.src_a = 0; i32.src_b = 0;
        i32.shamt = 0; i32.shamt_sel = 0;
        i16.start = 0; i16.alu_op = 0; i16.src_a = 0; i16.src_b = 0;
        i16.shamt = 0; i16.shamt_sel = 0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        check("reset16.out", {16'h0, i16.alu_out}, 32'd0);
        check("reset16.done", 32'(i16.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(i, tbl[i]);
        end

        // Start during SHIFT (or DONE in the fast build) is dropped.
        v = tbl[5];
`ifdef LU_SHIFT_FAST_EN
        start_k = 0;
`else
        start_k = 1;
`endif
        drive(v);
        @(posedge clk); #1;
        release_inputs(1'b0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (i32.done) begin
                dones++;
                if (dones == 1) cmp_pop("busy_start", 1'b0);
            end
            if (k == start_k) begin
                i32.start = 1'b1;
                i32.alu_op = LU_OP_ADD;
            end else begin
                i32.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (dones == 0) void'(sbq.pop_front());
        check("busy_start.dones", 32'(dones), 32'd1);

        // Start held through the DONE cycle is dropped too.
        v = '{0, LU_OP_ADD, 32'h1, 32'h2, 0, 0, 32'h3, 0, 0, 1, 0, 0};
        drive(v);
        @(posedge clk); #1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) i32.start = 1'b0;
            if (i32.done) begin
                dones++;
                if (dones == 1) cmp_pop("done_start", 1'b0);
            end
            @(posedge clk); #1;
        end
        if (dones == 0) void'(sbq.pop_front());
        check("done_start.dones", 32'(dones), 32'd1);

        // Reset in the middle of an 8-step shift aborts it silently.
        @(negedge clk);
        i32.start = 1'b1; i32.alu_op = LU_OP_SLL;
        i32.src_a = 0; i32.src_b = 32'h1;
        i32.shamt = 5'd8; i32.shamt_sel = 1'b0;
        @(posedge clk); #1;
        release_inputs(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_zero("abort");
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            if (i32.done) dones++;
            @(posedge clk); #1;
        end
        check("abort.dones", 32'(dones), 32'd0);
        check("scoreboard.empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_mc.md
Name: logic_unit_mc

Overview:
- Parametrised multicycle execution unit for the multicycle processor datapath.
- Combines an arithmetic/logic core, an iterative shifter and a branch-condition evaluator behind one start/done handshake.
- Sits between the ALUSrcA/ALUSrcB muxes and the ALUOut register.
- The control unit issues an op, waits for done, then samples the result and flags.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 8, power of 2).
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH) (elaboration assertion).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  op request; sampled only in IDLE.
- alu_op  input  4  operation code (lu_pkg).
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; also the shift operand.
- shamt  input  SHAMT_W  immediate shift amount.
- shamt_sel  input  1  0: amount = shamt; 1: amount = src_a[SHAMT_W-1:0].
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result and flags are valid on this cycle and held afterwards.
- alu_out  output  WIDTH  registered result.
- zero  output  1  alu_out == 0.
- overflow  output  1  signed overflow (ADD/SUB/INC only, else 0).
- special  output  1  signed src_a < src_b (all ops).
- br_taken  output  1  branch condition result (branch ops only, else 0).

Behaviour:
- Reset (any state): state = IDLE; every output is 0; the shift counter is cleared; no done is emitted for an aborted op.
- Operands and op are captured at the accepted start; later input changes do not affect the op.
- Op codes:
  - 0 PASS_A, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT_A, 7 INC_A (A+1), 8 SLT.
  - 9 SLL, 10 SRL, 11 SRA, 12 ROR.
  - 13 BEQ, 14 BNE, 15 BGT (signed A > B).
- SLT result: zero-extended special bit.
- Branch ops: alu_out = A−B; br_taken = the condition.
- FSM states IDLE, SHIFT, DONE:
  - IDLE + start + non-shift op → DONE; results registered in that edge. Latency: done on cycle start+1.
  - IDLE + start + shift op → SHIFT, with shreg = src_b and cnt = amount.
  - SHIFT: each cycle, if cnt != 0, shreg shifts by 1 bit and cnt decrements. When cnt == 0, go to DONE with alu_out = shreg.
  - Shift latency: done on cycle start+amount+2; amount 0 gives done at start+2, with alu_out = src_b.
  - DONE: done = 1 for exactly one cycle → IDLE. start is ignored in DONE; back-to-back issue is possible from the next cycle.
- Shift semantics:
  - SRA replicates the MSB.
  - ROR rotates right.
  - Amount is always modulo WIDTH; the shift never exceeds WIDTH−1 steps.
- Arithmetic is modulo 2^WIDTH.
- Overflow:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
- start while busy or in DONE is dropped; it is not queued.
- Illegal states recover to IDLE.

Optional Feature:
- Macro: LU_SHIFT_FAST_EN.
- Defined: shifts use a single-cycle barrel shifter; every op has done at start+1, and the SHIFT state and counter are removed.
- Undefined: iterative shifter exactly as above.
- Results and flags are bit-identical in both builds; only latency differs.

Decomposition:
- Package lu_pkg: op-code localparams (LU_OP_*), FSM state encodings, an is_shift_op function.
- One natural sub-module, lu_shift_iter:
  - holds shreg and cnt;
  - interface: load, mode[1:0], amount, operand, result, finished;
  - under LU_SHIFT_FAST_EN it becomes a combinational barrel shifter.
- The arithmetic core and branch compare stay inline in logic_unit_mc.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1 → done at start+1; alu_out=0x80000000, overflow=1, zero=0.
- SUB/BEQ, A=B=0x1234 → alu_out=0, zero=1, br_taken=1; BNE with the same operands → br_taken=0. SLT A=0xFFFFFFFF, B=1 → alu_out=1, special=1.
- SRA, B=0xF0000000, shamt=4, shamt_sel=0:
  - → busy for 5 cycles, done at start+6, alu_out=0xFF000000;
  - fast build: done at start+1, same value.
- ROR, B=0x00000001, src_a=0x21, shamt_sel=1 (amount 1) → alu_out=0x80000000. SLL with amount 0 → alu_out=B, done at start+2.
- Second start asserted during SHIFT → ignored, exactly one done pulse. Reset asserted mid-SHIFT → next cycle busy=0, all outputs 0, and no done.
- WIDTH=16, SHAMT_W=4 instance: ADD 0xFFFF+1 → alu_out=0, zero=1, overflow=0. SRL by 15 of 0x8000 → 0x0001.
